// File: rtl/mac_fixed_point_pipelined_pkg.sv
// Shared constants, rounding-mode encoding and width helpers for the
// pipelined fixed-point multiply-accumulate block.
package mac_fixed_point_pipelined_pkg;

    localparam int unsigned DEF_N     = 16;
    localparam int unsigned DEF_Q     = 12;
    localparam int unsigned DEF_GUARD = 8;
    localparam int unsigned MAX_W     = 64;

    typedef enum logic {
        ROUND_TRUNC   = 1'b0,
        ROUND_HALF_UP = 1'b1
    } round_mode_e;

    // Default-width saturation limits, handy for benches and wrappers.
    localparam logic signed [DEF_N-1:0] SAT_MAX_DEF = 16'sh7FFF;
    localparam logic signed [DEF_N-1:0] SAT_MIN_DEF = 16'sh8000;

    function automatic int unsigned acc_width(input int unsigned n,
                                              input int unsigned q,
                                              input int unsigned guard);
        return 2 * n - q + guard;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_max(input int unsigned n);
        return (MAX_W'(1) <<< (n - 1)) - MAX_W'(1);
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_min(input int unsigned n);
        return -(MAX_W'(1) <<< (n - 1));
    endfunction

endpackage

// File: rtl/fixed_point_mul_round.sv
// Combinational signed multiplier plus Q-shift scaler with optional
// round-half-up; the product path and the scale path are independent.
module fixed_point_mul_round
    import mac_fixed_point_pipelined_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned Q     = DEF_Q,
    parameter int unsigned ROUND = 1
) (
    input  logic signed [N-1:0]     i_a,
    input  logic signed [N-1:0]     i_b,
    input  logic signed [2*N-1:0]   i_product,
    output logic signed [2*N-1:0]   o_product,
    output logic signed [2*N-Q-1:0] o_scaled
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned BW = PW + 1;
    localparam int unsigned SW = PW - Q;

    // Half an output LSB, added before the floor shift to round half up.
    localparam logic signed [BW-1:0] BIAS =
        (ROUND == int'(ROUND_HALF_UP)) ? (BW'(1) <<< (Q - 1)) : '0;

    logic signed [BW-1:0] w_biased;
    logic signed [BW-1:0] w_shifted;

    assign o_product = PW'(i_a) * PW'(i_b);

    // One extra bit keeps the bias add from wrapping on the most positive product.
    assign w_biased  = BW'(i_product) + BIAS;
    assign w_shifted = w_biased >>> Q;
    assign o_scaled  = SW'(w_shifted);

endmodule

// File: rtl/mac_fixed_point_pipelined.sv
// Three-stage fixed-point MAC: operand register, full product, then
// scale/accumulate/saturate with a valid/ready output and sticky overflow.
module mac_fixed_point_pipelined
    import mac_fixed_point_pipelined_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned Q     = DEF_Q,
    parameter int unsigned GUARD = DEF_GUARD,
    parameter int unsigned ROUND = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_a,
    input  logic signed [N-1:0] in_b,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_result,
    output logic                out_overflow,
    input  logic                clear_ovf,
    output logic                ovf_sticky
);

    localparam int unsigned PW    = 2 * N;
    localparam int unsigned SW    = 2 * N - Q;
    localparam int unsigned ACC_W = acc_width(N, Q, GUARD);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(N));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(N));

    logic                    w_stall;
    logic                    w_accept;

    logic                    r_s1_valid;
    logic                    r_s1_last;
    logic signed [N-1:0]     r_s1_a;
    logic signed [N-1:0]     r_s1_b;

    logic                    r_s2_valid;
    logic                    r_s2_last;
    logic signed [PW-1:0]    r_s2_prod;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_out_valid;
    logic [N-1:0]            r_out_result;
    logic                    r_out_overflow;
    logic                    r_ovf_sticky;

    logic signed [PW-1:0]    w_product;
    logic signed [SW-1:0]    w_scaled;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    logic [N-1:0]            w_sat_val;

    logic signed [ACC_W-1:0] w_acc_nxt;
    logic                    w_out_valid_nxt;
    logic [N-1:0]            w_out_result_nxt;
    logic                    w_out_overflow_nxt;
    logic                    w_ovf_sticky_nxt;

    // A presented but unaccepted result freezes the whole pipeline.
    assign w_stall  = r_out_valid & ~out_ready;
    assign w_accept = in_valid & ~w_stall;

    fixed_point_mul_round #(
        .N     (N),
        .Q     (Q),
        .ROUND (ROUND)
    ) u_mul_round (
        .i_a       (r_s1_a),
        .i_b       (r_s1_b),
        .i_product (r_s2_prod),
        .o_product (w_product),
        .o_scaled  (w_scaled)
    );

    assign w_sum    = r_acc + ACC_W'(w_scaled);
    assign w_sat_hi = (w_sum > SAT_HI);
    assign w_sat_lo = (w_sum < SAT_LO);

    always_comb begin
        w_sat_val = N'(w_sum);
        if (w_sat_hi) begin
            w_sat_val = N'(SAT_HI);
        end else if (w_sat_lo) begin
            w_sat_val = N'(SAT_LO);
        end
    end

    // Stage 3 next state: accumulate, or emit and clear on a last beat.
    always_comb begin
        w_acc_nxt          = r_acc;
        w_out_valid_nxt    = r_out_valid;
        w_out_result_nxt   = r_out_result;
        w_out_overflow_nxt = r_out_overflow;
        w_ovf_sticky_nxt   = r_ovf_sticky & ~clear_ovf;
        if (!w_stall) begin
            w_out_valid_nxt = 1'b0;
            if (r_s2_valid) begin
                if (r_s2_last) begin
                    w_acc_nxt          = '0;
                    w_out_valid_nxt    = 1'b1;
                    w_out_result_nxt   = w_sat_val;
                    w_out_overflow_nxt = w_sat_hi | w_sat_lo;
                    w_ovf_sticky_nxt   = w_ovf_sticky_nxt | w_sat_hi | w_sat_lo;
                end else begin
                    w_acc_nxt = w_sum;
                end
            end
        end
    end

    // Stages 1 and 2 advance together whenever the output is not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_prod  <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            r_s1_last  <= in_last;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_prod  <= w_product;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc          <= '0;
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_overflow <= 1'b0;
            r_ovf_sticky   <= 1'b0;
        end else begin
            r_acc          <= w_acc_nxt;
            r_out_valid    <= w_out_valid_nxt;
            r_out_result   <= w_out_result_nxt;
            r_out_overflow <= w_out_overflow_nxt;
            r_ovf_sticky   <= w_ovf_sticky_nxt;
        end
    end

    assign in_ready     = ~w_stall;
    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_overflow = r_out_overflow;
    assign ovf_sticky   = r_ovf_sticky;

endmodule

// File: doc/mac_fixed_point_pipelined.md
MAC_FIXED_POINT_PIPELINED -- requirements
Module: mac_fixed_point_pipelined

Interface
REQ-001 Parameter N, default 16, total operand/result width in bits, two's complement.
REQ-002 Parameter Q, default 12, fractional bits of operands and result.
REQ-003 Parameter GUARD, default 8, accumulator guard bits above the scaled-product width.
REQ-004 Parameter ROUND, default 1; 0 = truncate toward minus infinity, 1 = round half up.
REQ-005 clk  input  1  single clock; all state is updated on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  operand beat is present.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_a, in_b  input  N  signed Q-format operands.
REQ-010 in_last  input  1  beat is the final beat of a dot-product vector.
REQ-011 out_valid  output  1  result is present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_result  output  N  saturated signed Q-format sum.
REQ-014 out_overflow  output  1  out_result was saturated.
REQ-015 clear_ovf  input  1  clears ovf_sticky.
REQ-016 ovf_sticky  output  1  set by any saturated result and held until clear_ovf or reset.

Function
REQ-017 A beat SHALL be accepted when in_valid && in_ready.
REQ-018 Stall = out_valid && !out_ready; in_ready SHALL equal !stall, and all pipeline registers SHALL hold while stall is asserted.
REQ-019 Stage 1 SHALL register the operands and last flag; stage 2 SHALL form the full signed 2N-bit product; stage 3 SHALL scale, accumulate and saturate.
REQ-020 Scaling SHALL be an arithmetic right shift by Q; when ROUND=1, 2^(Q-1) SHALL be added before the shift.
REQ-021 The accumulator SHALL be 2N-Q+GUARD bits wide and SHALL NOT wrap for vectors of at most 2^GUARD beats; longer vectors are out of contract.
REQ-022 On a last beat in stage 3, out_result SHALL be acc+product saturated to [-2^(N-1), 2^(N-1)-1], out_valid SHALL rise, and the accumulator SHALL clear to 0 in the same edge.
REQ-023 out_overflow SHALL be 1 exactly when saturation changed the value; ovf_sticky SHALL set on the same edge.
REQ-024 Latency from acceptance of a last beat to out_valid SHALL be 3 cycles with no stall; throughput SHALL be one beat per cycle.
REQ-025 A beat with in_last=1 on every cycle SHALL give pure-multiplier operation at one result per cycle.
REQ-026 out_result and out_overflow SHALL remain stable while out_valid && !out_ready.
REQ-027 If clear_ovf and a new saturation coincide, ovf_sticky SHALL end set.
REQ-028 Bubbles (no accepted beat) SHALL not change the accumulator.

Reset
REQ-029 While rst_n=0: in_ready=1, out_valid=0, out_result=0, out_overflow=0, ovf_sticky=0, accumulator and all stage-valid bits 0.
REQ-030 Reset asserted mid-vector SHALL discard the partial sum; the first beat after release starts a new vector.

Structure
REQ-031 A shared package SHALL hold the saturation limit constants, the ROUND mode encoding and a function computing accumulator width from N, Q and GUARD.
REQ-032 The signed multiply, scale and round SHALL live in one sub-module, fixed_point_mul_round, combinational, reused by stage 2 and stage 3.

Verification
REQ-033 N=16,Q=12: a=0x1000, b=0x1000, last=1 -> out_result=0x1000, out_overflow=0, out_valid 3 cycles after acceptance.
REQ-034 a=0x7000, b=0x7000, last=1 -> out_result=0x7FFF, out_overflow=1, ovf_sticky=1 until clear_ovf pulse.
REQ-035 a=0xF000, b=0x2000 -> 0xE000; a=0x0001, b=0x0800 -> 0x0001 with ROUND=1, 0x0000 with ROUND=0.
REQ-036 Four beats a=0x0800, b=0x1000, last on the fourth -> single output 0x2000; next vector starts from 0.
REQ-037 Back-to-back last beats with out_ready held 0 for 5 cycles -> in_ready=0, result held stable, no beat lost or duplicated after release.
REQ-038 Reset pulse after two beats of a vector, then one beat a=0x1000, b=0x1000, last=1 -> 0x1000.
